spi_lan_burst_engine: RTL and testbench
=======================================

// Module: spi_lan_burst_engine
// PURPOSE
//  Upstream sequencer for the LAN SPI master port. It turns one burst request (N bytes)
//  into register accesses on that port: clear status, assert SS, then write and read back each byte, then release SS.
//  TX bytes are pulled from a valid/ready stream; RX bytes are pushed to a valid/ready stream.
//  The first `req_skip` RX bytes (command/address echo) are dropped.
// PARAMETERS
//  LEN_W        11    width of burst length / skip counters (max burst 2**LEN_W-1 bytes)
//  TIMEOUT_CYC  4096  clk cycles allowed in WAIT_RRDY before abort (SPI_BURST_TIMEOUT_EN only)
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      async active-low reset
//  req_valid      in   1      burst request valid
//  req_ready      out  1      engine idle; request accepted when valid&ready
//  req_len        in   LEN_W  total bytes to shift; 0 is illegal and treated as 1
//  req_skip       in   LEN_W  leading RX bytes to discard (clamped to req_len)
//  tx_data/valid  in   8/1    TX byte stream
//  tx_ready       out  1      TX byte consumed
//  rx_data/valid  out  8/1    RX byte stream
//  rx_ready       in   1      RX sink ready
//  busy, done     out  1/1    busy = not IDLE; done = 1-cycle pulse at end of burst
//  err            out  1      sticky timeout flag, cleared on next request accept
//  spi_select, read_n, write_n  out 1  SPI master access strobes
//  mem_addr       out  3      SPI master register address
//  data_from_cpu  out  16     SPI master write data
//  data_to_cpu    in   16     SPI master read data
//  readyfordata, dataavailable  in 1  SPI master TRDY / RRDY
// BEHAVIOUR
//  Reset values: req_ready=1, all other outputs 0, read_n=write_n=1, state IDLE.
//  Port access: every access holds spi_select, the r/w strobe, mem_addr and data for exactly 2 clks.
//    Read data is sampled from data_to_cpu on the clk after the 2nd strobe cycle.
//    At least 1 idle clk separates consecutive accesses (strobes high, spi_select 0).
//  FSM states: IDLE, CLR, SS_ON, WAIT_T, WR, WAIT_R, RD, RD_CAP, PUSH, SS_OFF, DONE.
//    IDLE   -> CLR    on req accept; latch len/skip, byte counter = 0, err = 0.
//    CLR    write addr2 (any data; clears status)                     -> SS_ON.
//    SS_ON  write addr3 = 16'h0400 (SSO forced)                       -> WAIT_T.
//    WAIT_T wait for readyfordata & tx_valid                          -> WR.
//    WR     write addr1 = {8'h0, tx_data}; tx_ready pulses 1 clk on the 1st strobe cycle -> WAIT_R.
//    WAIT_R wait for dataavailable                                    -> RD.
//    RD     read addr0 (2 clks)                                       -> RD_CAP.
//    RD_CAP latch data_to_cpu[7:0]; byte index < skip -> NEXT, else -> PUSH.
//    PUSH   rx_valid=1 until rx_ready; rx_data stays stable           -> NEXT.
//    NEXT   counter+1; counter==len -> SS_OFF, else -> WAIT_T.
//           NEXT is a decision folded into RD_CAP/PUSH, not a separate clk.
//    SS_OFF write addr3 = 16'h0000                                    -> DONE.
//    DONE   done=1 for 1 clk                                          -> IDLE.
//  Backpressure: a stalled rx sink stalls the burst. SS stays asserted; no SPI byte is lost.
//  Only one byte is ever in flight, so the SPI master ROE/TOE never set in normal operation.
//  Counters are LEN_W bits and never wrap: len is at most 2**LEN_W-1.
//  req_valid while busy is ignored (req_ready=0).
//  Async reset mid-burst returns to IDLE immediately. SS release is the downstream block's own reset duty.
// CONFIGURATION
//  SPI_BURST_TIMEOUT_EN defined:
//    cycle counter runs in WAIT_R; reaching TIMEOUT_CYC sets err and jumps to SS_OFF.
//    done still pulses; remaining tx bytes are not consumed.
//  SPI_BURST_TIMEOUT_EN undefined: no counter, err tied 0, WAIT_R waits indefinitely.
// STRUCTURE
//  Package spi_lan_pkg: state enum, register address constants (RXDATA=0, TXDATA=1, STATUS=2,
//    CONTROL=3, SSEL=5, EOPVAL=6), CTRL_SSO_BIT=10.
//  Sub-module spi_lan_acc: 2-clk strobe generator plus idle gap.
//    Interface: start/addr/wdata/is_read in; ack/rdata out. The FSM issues all accesses through it.
// TESTING
//  Bench uses a behavioural SPI master model with MISO looped to MOSI.
//  1 len=3 skip=0, tx 8'hA5,8'h3C,8'hFF
//    -> rx A5,3C,FF; access order 2,3,(1,0)x3,3; done once; busy low after.
//  2 len=4 skip=2, tx 11,22,33,44 -> rx only 33,44; tx_ready pulses 4 times.
//  3 rx_ready held 0 for 200 clks after byte 1 -> no addr1 write during stall; rx data intact.
//  4 req_valid pulsed while busy -> ignored; the next request after done runs normally.
//  5 reset_n low mid-WR -> all strobes 1, spi_select 0, req_ready 1 on the next clk.
//  6 (SPI_BURST_TIMEOUT_EN, TIMEOUT_CYC=64) dataavailable never rises
//    -> err=1 at WAIT_R entry+64; addr3=0 written; done pulses.

Source files
------------

// File: rtl/spi_lan_pkg.sv
// spi_lan_pkg: shared state/phase types and SPI master register map for the LAN SPI burst engine
package spi_lan_pkg;

    typedef enum logic [3:0] {
        IDLE, CLR, SS_ON, WAIT_T, WR, WAIT_R, RD, RD_CAP, PUSH, SS_OFF, DONE
    } state_t;

    typedef enum logic [1:0] {PH_IDLE, PH_STB1, PH_STB2, PH_GAP} phase_t;

    localparam logic [2:0] RXDATA  = 3'd0;
    localparam logic [2:0] TXDATA  = 3'd1;
    localparam logic [2:0] STATUS  = 3'd2;
    localparam logic [2:0] CONTROL = 3'd3;
    localparam logic [2:0] SSEL    = 3'd5;
    localparam logic [2:0] EOPVAL  = 3'd6;

    localparam int CTRL_SSO_BIT = 10;

    function automatic logic [15:0] ctrl_word(input logic sso);
        return sso ? (16'(1) << CTRL_SSO_BIT) : 16'h0000;
    endfunction

endpackage

// File: rtl/spi_lan_acc.sv
// spi_lan_acc: one SPI master register access -- strobes held 2 clks, then one idle gap clk with ack
module spi_lan_acc
    import spi_lan_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    input  logic        is_read,
    output logic        ack,
    output logic        first,
    output logic [15:0] rdata,
    output logic        spi_select,
    output logic        read_n,
    output logic        write_n,
    output logic [2:0]  mem_addr,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu
);

    phase_t      phase_q, phase_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        is_read_q, is_read_d;
    logic [15:0] rdata_q, rdata_d;
    logic        sel;

    // Phase sequencing; request fields are captured only when a new access is accepted
    always_comb begin
        phase_d   = phase_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        is_read_d = is_read_q;
        rdata_d   = rdata_q;
        case (phase_q)
            PH_IDLE: if (start) begin
                phase_d   = PH_STB1;
                addr_d    = addr;
                wdata_d   = wdata;
                is_read_d = is_read;
            end
            PH_STB1: phase_d = PH_STB2;
            PH_STB2: begin
                phase_d = PH_GAP;
                rdata_d = is_read_q ? data_to_cpu : rdata_q;
            end
            default: phase_d = PH_IDLE;
        endcase
    end

    // Access registers; strobes come straight from these so reset releases the port at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= PH_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            is_read_q <= 1'b0;
            rdata_q   <= '0;
        end else begin
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            is_read_q <= is_read_d;
            rdata_q   <= rdata_d;
        end
    end

    assign sel           = (phase_q == PH_STB1) || (phase_q == PH_STB2);
    assign spi_select    = sel;
    assign read_n        = !(sel && is_read_q);
    assign write_n       = !(sel && !is_read_q);
    assign mem_addr      = sel ? addr_q : 3'd0;
    assign data_from_cpu = (sel && !is_read_q) ? wdata_q : 16'h0000;
    assign ack           = phase_q == PH_GAP;
    assign first         = phase_q == PH_STB1;
    assign rdata         = rdata_q;

endmodule

// File: rtl/spi_lan_burst_engine.sv
// spi_lan_burst_engine: turns one N-byte burst request into LAN SPI master register accesses
// (optional WAIT_R timeout enabled by defining SPI_BURST_TIMEOUT_EN)
module spi_lan_burst_engine
    import spi_lan_pkg::*;
#(
    parameter int LEN_W       = 11,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [LEN_W-1:0] req_len,
    input  logic [LEN_W-1:0] req_skip,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             spi_select,
    output logic             read_n,
    output logic             write_n,
    output logic [2:0]       mem_addr,
    output logic [15:0]      data_from_cpu,
    input  logic [15:0]      data_to_cpu,
    input  logic             readyfordata,
    input  logic             dataavailable
);

    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] skip_q, skip_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic [LEN_W-1:0] len_eff, skip_eff, cnt_inc;
    logic             last;
    logic             acc_start, acc_is_read, acc_ack, acc_first;
    logic [2:0]       acc_addr;
    logic [15:0]      acc_wdata, acc_rdata;
    logic             unused_rdata_hi;

`ifdef SPI_BURST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    spi_lan_acc u_acc (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (acc_start),
        .addr         (acc_addr),
        .wdata        (acc_wdata),
        .is_read      (acc_is_read),
        .ack          (acc_ack),
        .first        (acc_first),
        .rdata        (acc_rdata),
        .spi_select   (spi_select),
        .read_n       (read_n),
        .write_n      (write_n),
        .mem_addr     (mem_addr),
        .data_from_cpu(data_from_cpu),
        .data_to_cpu  (data_to_cpu)
    );

    // Burst sequencer: next state, counters and the access request for the current step
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        skip_d      = skip_q;
        cnt_d       = cnt_q;
        rx_data_d   = rx_data_q;
        acc_start   = 1'b0;
        acc_addr    = RXDATA;
        acc_wdata   = 16'h0000;
        acc_is_read = 1'b0;
        len_eff     = (req_len == '0) ? LEN_W'(1) : req_len;
        skip_eff    = (req_skip > len_eff) ? len_eff : req_skip;
        cnt_inc     = cnt_q + LEN_W'(1);
        last        = cnt_inc == len_q;
`ifdef SPI_BURST_TIMEOUT_EN
        err_d       = err_q;
        tmo_d       = (state_q == WAIT_R) ? tmo_q + TMO_W'(1) : '0;
`endif
        case (state_q)
            IDLE: if (req_valid) begin
                state_d = CLR;
                len_d   = len_eff;
                skip_d  = skip_eff;
                cnt_d   = '0;
`ifdef SPI_BURST_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            CLR: begin
                acc_start = 1'b1;
                acc_addr  = STATUS;
                state_d   = acc_ack ? SS_ON : CLR;
            end
            SS_ON: begin
                acc_start = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctrl_word(1'b1);
                state_d   = acc_ack ? WAIT_T : SS_ON;
            end
            WAIT_T: state_d = (readyfordata && tx_valid) ? WR : WAIT_T;
            WR: begin
                acc_start = 1'b1;
                acc_addr  = TXDATA;
                acc_wdata = {8'h00, tx_data};
                state_d   = acc_ack ? WAIT_R : WR;
            end
            WAIT_R: begin
                if (dataavailable) state_d = RD;
`ifdef SPI_BURST_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = SS_OFF;
                end
`endif
            end
            RD: begin
                acc_start   = 1'b1;
                acc_is_read = 1'b1;
                acc_addr    = RXDATA;
                state_d     = acc_ack ? RD_CAP : RD;
            end
            RD_CAP: begin
                rx_data_d = acc_rdata[7:0];
                if (cnt_q < skip_q) begin
                    cnt_d   = cnt_inc;
                    state_d = last ? SS_OFF : WAIT_T;
                end else begin
                    state_d = PUSH;
                end
            end
            PUSH: if (rx_ready) begin
                cnt_d   = cnt_inc;
                state_d = last ? SS_OFF : WAIT_T;
            end
            SS_OFF: begin
                acc_start = 1'b1;
                acc_addr  = CONTROL;
                acc_wdata = ctrl_word(1'b0);
                state_d   = acc_ack ? DONE : SS_OFF;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Sequencer state and burst bookkeeping registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            len_q     <= '0;
            skip_q    <= '0;
            cnt_q     <= '0;
            rx_data_q <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            skip_q    <= skip_d;
            cnt_q     <= cnt_d;
            rx_data_q <= rx_data_d;
        end
    end

`ifdef SPI_BURST_TIMEOUT_EN
    // WAIT_R watchdog counter and sticky timeout flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign unused_rdata_hi = ^acc_rdata[15:8];
    assign req_ready       = state_q == IDLE;
    assign busy            = state_q != IDLE;
    assign done            = state_q == DONE;
    assign rx_valid        = state_q == PUSH;
    assign rx_data         = rx_data_q;
    assign tx_ready        = (state_q == WR) && acc_first;

endmodule

// File: tb/tb_spi_lan_burst_engine.sv
// tb_spi_lan_burst_engine: directed bursts against a loopback SPI master model with a per-cycle checker
module tb_spi_lan_burst_engine;

    localparam int LEN_W = 11;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [LEN_W-1:0] req_len = '0;
    logic [LEN_W-1:0] req_skip = '0;
    logic [7:0]       tx_data = 8'h00;
    logic             tx_valid = 1'b0;
    logic             tx_ready;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready = 1'b1;
    logic             busy, done, err, spi_select, read_n, write_n;
    logic [2:0]       mem_addr;
    logic [15:0]      data_from_cpu;
    logic [15:0]      data_to_cpu = 16'h5A00;
    logic             readyfordata = 1'b1;
    logic             dataavailable = 1'b0;

    always #5 clk = ~clk;

    spi_lan_burst_engine #(.LEN_W(LEN_W), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_len(req_len), .req_skip(req_skip), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .busy(busy), .done(done), .err(err), .spi_select(spi_select), .read_n(read_n),
        .write_n(write_n), .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
        .data_to_cpu(data_to_cpu), .readyfordata(readyfordata), .dataavailable(dataavailable)
    );

    int n_chk = 0;
    int n_fail = 0;

    // stimulus-owned burst description
    logic [7:0]  tx_buf [16];
    logic [7:0]  exp_rx [16];
    int          tx_n = 0, exp_n = 0, gen = 0;
    logic        exp_err = 1'b0, mute = 1'b0, stall = 1'b0;

    // monitor-owned observations
    int          seen_gen = 0, cyc = 0, tx_idx = 0, rx_idx = 0, n_acc = 0, n_ctrl = 0;
    int          tx_pulses = 0, done_cnt = 0, wr_blocked = 0, sel_run = 0, shift = 0;
    int          err_cyc = 0, wr_end_cyc = 0;
    logic [2:0]  acc_log [64];
    logic [15:0] ctrl_log [8];
    logic [7:0]  rx_got [16];
    logic [7:0]  rxreg = 8'h00, pend = 8'h00, prev_data = 8'h00;
    logic        prev_stuck = 1'b0, blocked = 1'b0, stall_hit = 1'b0, err_seen = 1'b0, last_wr1 = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // SPI master model (MISO looped to MOSI), TX source, RX scoreboard and protocol checks
    always @(negedge clk) begin
        cyc++;
        if (gen != seen_gen) begin
            seen_gen = gen; tx_idx = 0; rx_idx = 0; n_acc = 0; n_ctrl = 0; tx_pulses = 0;
            done_cnt = 0; wr_blocked = 0; stall_hit = 0; err_seen = 0; err_cyc = 0; wr_end_cyc = 0;
        end
        if (!reset_n) begin
            readyfordata = 1'b1; dataavailable = 1'b0; shift = 0; sel_run = 0;
            prev_stuck = 1'b0; last_wr1 = 1'b0; blocked = 1'b0;
        end else begin
            if (prev_stuck) begin
                chk("rx_hold_valid", rx_valid, 1);
                chk("rx_hold_data", rx_data, prev_data);
            end
            if (rx_valid && rx_ready) begin
                if (rx_idx < exp_n) chk("rx_data", rx_data, exp_rx[rx_idx]);
                else chk("rx_extra", rx_idx, exp_n);
                if (rx_idx < 16) rx_got[rx_idx] = rx_data;
                rx_idx++;
            end
            prev_stuck = rx_valid && !rx_ready;
            prev_data  = rx_data;
            blocked    = stall && (blocked || (rx_valid && !rx_ready));
            if (blocked) stall_hit = 1'b1;
            if (tx_ready) begin
                chk("tx_ready_with_valid", tx_valid, 1);
                tx_pulses++;
                tx_idx++;
            end
            if (done) begin
                done_cnt++;
                chk("err_at_done", err, exp_err);
            end
            if (err && !err_seen) begin
                err_seen = 1'b1;
                err_cyc  = cyc;
            end
            if (spi_select) begin
                sel_run++;
                if (sel_run == 1) begin
                    if (n_acc < 64) acc_log[n_acc] = mem_addr;
                    n_acc++;
                    last_wr1 = !write_n && mem_addr == 3'd1;
                    if (last_wr1) begin
                        shift = 8; readyfordata = 1'b0; pend = data_from_cpu[7:0];
                        if (blocked) wr_blocked++;
                    end
                    if (!write_n && mem_addr == 3'd3) begin
                        if (n_ctrl < 8) ctrl_log[n_ctrl] = data_from_cpu;
                        n_ctrl++;
                    end
                    if (!read_n && mem_addr == 3'd0) dataavailable = 1'b0;
                end
            end else if (sel_run != 0) begin
                chk("strobe_width", sel_run, 2);
                if (last_wr1) wr_end_cyc = cyc;
                sel_run = 0;
            end
            if (shift != 0) begin
                shift--;
                if (shift == 0) begin
                    rxreg = pend; readyfordata = 1'b1; dataavailable = !mute;
                end
            end
        end
        data_to_cpu = {8'h5A, rxreg};
        tx_valid    = tx_idx < tx_n;
        tx_data     = tx_buf[tx_idx[3:0]];
    end

    task automatic start_burst(input int len, input int skip, input int n);
        int el, es;
        el = (len == 0) ? 1 : len;
        es = (skip > el) ? el : skip;
        exp_n = 0;
        for (int i = es; i < el; i++) begin
            exp_rx[exp_n] = tx_buf[i];
            exp_n++;
        end
        tx_n = n;
        gen++;
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1; req_len = LEN_W'(len); req_skip = LEN_W'(skip);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input int limit, input int exp_tx);
        int c;
        c = 0;
        while (done_cnt == 0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("busy_after", busy, 0);
        chk("rx_count", rx_idx, exp_n);
        chk("tx_pulses", tx_pulses, exp_tx);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] t1_acc [9];
        int c;
        t1_acc = '{3'd2, 3'd3, 3'd1, 3'd0, 3'd1, 3'd0, 3'd1, 3'd0, 3'd3};
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_spi_select", spi_select, 0);
        chk("rst_read_n", read_n, 1);
        chk("rst_write_n", write_n, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_wdata", data_from_cpu, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: plain three-byte burst
        tx_buf[0] = 8'hA5; tx_buf[1] = 8'h3C; tx_buf[2] = 8'hFF;
        start_burst(3, 0, 3);
        wait_done(2000, 3);
        chk("t1_acc_count", n_acc, 9);
        for (int i = 0; i < 9; i++) chk("t1_acc_order", acc_log[i], t1_acc[i]);
        chk("t1_sso_on", ctrl_log[0], 16'h0400);
        chk("t1_sso_off", ctrl_log[1], 16'h0000);
        chk("t1_rx0", rx_got[0], 8'hA5);
        chk("t1_rx1", rx_got[1], 8'h3C);
        chk("t1_rx2", rx_got[2], 8'hFF);

        // 2: skip the first two echoed bytes
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22; tx_buf[2] = 8'h33; tx_buf[3] = 8'h44;
        start_burst(4, 2, 4);
        wait_done(2000, 4);
        chk("t2_rx_count", rx_idx, 2);
        chk("t2_rx0", rx_got[0], 8'h33);
        chk("t2_rx1", rx_got[1], 8'h44);
        chk("t2_acc_count", n_acc, 11);

        // 3: rx sink stalls for 200 clks after the first byte
        tx_buf[0] = 8'h01; tx_buf[1] = 8'h02; tx_buf[2] = 8'h03;
        fork
            begin
                start_burst(3, 0, 3);
                wait_done(3000, 3);
            end
            begin
                repeat (2) @(posedge clk);
                c = 0;
                while (rx_idx < 1 && c < 500) begin
                    @(negedge clk);
                    c++;
                end
                @(posedge clk); #1;
                rx_ready = 1'b0; stall = 1'b1;
                repeat (200) @(posedge clk);
                #1;
                rx_ready = 1'b1; stall = 1'b0;
            end
        join
        chk("t3_stall_hit", stall_hit, 1);
        chk("t3_no_wr_in_stall", wr_blocked, 0);
        chk("t3_rx1", rx_got[1], 8'h02);
        chk("t3_rx2", rx_got[2], 8'h03);

        // 4: request while busy is ignored
        tx_buf[0] = 8'h77; tx_buf[1] = 8'h88;
        fork
            begin
                start_burst(2, 0, 2);
                wait_done(2000, 2);
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                chk("t4_busy_req_ready", req_ready, 0);
                req_valid = 1'b1; req_len = LEN_W'(5);
                @(posedge clk); #1;
                req_valid = 1'b0;
            end
        join
        chk("t4_acc_count", n_acc, 7);
        tx_buf[0] = 8'h99;
        start_burst(1, 0, 1);
        wait_done(2000, 1);
        chk("t4_next_rx", rx_got[0], 8'h99);
        chk("t4_next_acc_count", n_acc, 5);

        // 5: async reset during the TX write
        tx_buf[0] = 8'h12; tx_buf[1] = 8'h34;
        start_burst(2, 0, 2);
        c = 0;
        while (!(spi_select && !write_n && mem_addr == 3'd1) && c < 300) begin
            @(negedge clk);
            c++;
        end
        chk("t5_saw_wr", spi_select && !write_n && mem_addr == 3'd1, 1);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        chk("t5_write_n", write_n, 1);
        chk("t5_read_n", read_n, 1);
        chk("t5_spi_select", spi_select, 0);
        chk("t5_req_ready", req_ready, 1);
        chk("t5_busy", busy, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

`ifdef SPI_BURST_TIMEOUT_EN
        // 6: dataavailable never rises -> timeout abort
        mute = 1'b1; exp_err = 1'b1;
        tx_buf[0] = 8'hAB; tx_buf[1] = 8'hCD;
        start_burst(2, 0, 2);
        exp_n = 0;
        wait_done(2000, 1);
        chk("t6_err_latency", err_cyc - wr_end_cyc, 65);
        chk("t6_err_sticky", err, 1);
        chk("t6_ctrl_count", n_ctrl, 2);
        chk("t6_sso_off", ctrl_log[1], 16'h0000);
        mute = 1'b0; exp_err = 1'b0;
        tx_buf[0] = 8'h5E;
        start_burst(1, 0, 1);
        @(negedge clk);
        chk("t6_err_cleared", err, 0);
        wait_done(2000, 1);
        chk("t6_next_rx", rx_got[0], 8'h5E);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
